// File: rtl/mem_req_ctrl.sv
// MEM-stage memory request controller: turns a MEM-stage load/store into one
// SRAM-like bus transaction, stalls the pipeline until it completes, and holds load data.
module mem_req_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  memenM,
    input  logic                  memwriteM,
    input  logic                  excM,
    input  logic [1:0]            sizeM,
    input  logic [ADDR_WIDTH-1:0] addrM,
    input  logic [31:0]           wdataM,
    input  logic                  stall_other,
    output logic                  stall_memM,
    output logic [31:0]           rdataM,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [31:0]           data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [31:0]           data_rdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic                  new_req;
    logic [SIZE_W-1:0]     size_norm;
    logic [DATA_W-1:0]     wdata_rep;
    logic                  req_load;
    logic                  rdata_load;

    logic                  req_wr_q;
    logic [SIZE_W-1:0]     req_size_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_W-1:0]     req_wdata_q;
    logic [DATA_W-1:0]     rdata_q;

    // Request qualification and store-lane replication
    always_comb begin
        new_req   = memenM & ~excM;
        size_norm = (sizeM == 2'd3) ? 2'd2 : sizeM;
        case (size_norm)
            2'd0:    wdata_rep = {4{wdataM[7:0]}};
            2'd1:    wdata_rep = {2{wdataM[15:0]}};
            default: wdata_rep = wdataM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and bus/pipeline outputs; IDLE presents the request straight from the inputs
    always_comb begin
        state_next = state;
        data_req   = 1'b0;
        data_wr    = req_wr_q;
        data_size  = req_size_q;
        data_addr  = req_addr_q;
        data_wdata = req_wdata_q;
        stall_memM = 1'b0;
        rdataM     = rdata_q;
        req_load   = 1'b0;
        rdata_load = 1'b0;

        case (state)
            IDLE: begin
                if (new_req) begin
                    data_req   = 1'b1;
                    data_wr    = memwriteM;
                    data_size  = size_norm;
                    data_addr  = addrM;
                    data_wdata = wdata_rep;
                    stall_memM = 1'b1;
                    req_load   = 1'b1;
                    state_next = data_addr_ok ? DATA : ADDR;
                end
            end
            ADDR: begin
                data_req   = 1'b1;
                stall_memM = 1'b1;
                if (data_addr_ok) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (data_data_ok) begin
                    rdataM     = data_rdata;
                    rdata_load = 1'b1;
                    state_next = stall_other ? HOLD : IDLE;
                end else begin
                    stall_memM = 1'b1;
                end
            end
            HOLD: begin
                // Same instruction still sits in MEM; wait for the pipeline to move on
                if (!stall_other) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_wr_q    <= 1'b0;
            req_size_q  <= SIZE_W'(0);
            req_addr_q  <= ADDR_WIDTH'(0);
            req_wdata_q <= DATA_W'(0);
        end else if (req_load) begin
            req_wr_q    <= memwriteM;
            req_size_q  <= size_norm;
            req_addr_q  <= addrM;
            req_wdata_q <= wdata_rep;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q <= DATA_W'(0);
        end else if (rdata_load) begin
            rdata_q <= data_rdata;
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed scenarios plus randomized
// transactions checked against a cycle-timeline model of the bus handshake.
module tb_mem_req_ctrl;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          memenM;
    logic          memwriteM;
    logic          excM;
    logic [1:0]    sizeM;
    logic [AW-1:0] addrM;
    logic [31:0]   wdataM;
    logic          stall_other;
    logic          stall_memM;
    logic [31:0]   rdataM;
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [31:0]   data_rdata;

    int checks = 0;
    int failures = 0;

    mem_req_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .memenM       (memenM),
        .memwriteM    (memwriteM),
        .excM         (excM),
        .sizeM        (sizeM),
        .addrM        (addrM),
        .wdataM       (wdataM),
        .stall_other  (stall_other),
        .stall_memM   (stall_memM),
        .rdataM       (rdataM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected lane replication computed arithmetically
    function automatic logic [31:0] repl(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0)      repl = {24'd0, wd[7:0]} * 32'h0101_0101;
        else if (sz == 2'd1) repl = {16'd0, wd[15:0]} * 32'h0001_0001;
        else                 repl = wd;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        memenM = 0; memwriteM = 0; excM = 0; sizeM = 0; addrM = 0; wdataM = 0;
        stall_other = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    endtask

    task automatic test_reset();
        quiet();
        resetn = 0;
        step(); step();
        @(negedge clk);
        checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0h exp=0", data_req); end
        checks++; if (stall_memM !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0h exp=0", stall_memM); end
        checks++; if (rdataM !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%0h exp=0", rdataM); end
        checks++; if ({data_wr, data_size, data_addr, data_wdata} !== 67'h0) begin
            failures++; $display("FAIL rst_bus got wr=%0h size=%0h addr=%0h wdata=%0h exp all 0", data_wr, data_size, data_addr, data_wdata);
        end
        step();
        resetn = 1;
        step();
    endtask

    task automatic test_load_word();
        quiet();
        memenM = 1; sizeM = 2; addrM = 32'h1000; data_addr_ok = 1;
        @(negedge clk);
        checks++; if (data_req !== 1'b1 || data_addr !== 32'h1000 || data_wr !== 1'b0 || data_size !== 2'd2) begin
            failures++; $display("FAIL lw_req got req=%0h addr=%0h wr=%0h size=%0h exp 1/1000/0/2", data_req, data_addr, data_wr, data_size);
        end
        checks++; if (stall_memM !== 1'b1) begin failures++; $display("FAIL lw_stall0 got=%0h exp=1", stall_memM); end
        step();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (stall_memM !== 1'b0) begin failures++; $display("FAIL lw_stall1 got=%0h exp=0", stall_memM); end
        checks++; if (rdataM !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_bypass got=%0h exp=deadbeef", rdataM); end
        checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL lw_req_data got=%0h exp=0", data_req); end
        step();
        quiet(); data_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        checks++; if (rdataM !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_held got=%0h exp=deadbeef", rdataM); end
        step();
    endtask

    task automatic test_store_byte_delayed();
        quiet();
        memenM = 1; memwriteM = 1; sizeM = 0; addrM = 32'h2003; wdataM = 32'h0000_005A;
        for (int c = 0; c < 4; c++) begin
            data_addr_ok = (c == 3);
            if (c > 0) begin
                addrM = $urandom; wdataM = $urandom; sizeM = 2'($urandom_range(0, 3)); memwriteM = 0;
            end
            @(negedge clk);
            checks++; if (data_req !== 1'b1 || data_addr !== 32'h2003 || data_size !== 2'd0 ||
                          data_wdata !== 32'h5A5A_5A5A || data_wr !== 1'b1) begin
                failures++; $display("FAIL sb_hold c=%0d got req=%0h addr=%0h size=%0h wdata=%0h wr=%0h exp 1/2003/0/5a5a5a5a/1",
                                     c, data_req, data_addr, data_size, data_wdata, data_wr);
            end
            checks++; if (stall_memM !== 1'b1) begin failures++; $display("FAIL sb_stall c=%0d got=%0h exp=1", c, stall_memM); end
            step();
        end
        memwriteM = 1; sizeM = 0; addrM = 32'h2003; wdataM = 32'h5A;
        data_addr_ok = 0;
        @(negedge clk);
        checks++; if (data_req !== 1'b0 || stall_memM !== 1'b1) begin
            failures++; $display("FAIL sb_data_wait got req=%0h stall=%0h exp 0/1", data_req, stall_memM);
        end
        step();
        data_data_ok = 1;
        @(negedge clk);
        checks++; if (stall_memM !== 1'b0) begin failures++; $display("FAIL sb_done got=%0h exp=0", stall_memM); end
        step();
        quiet();
        step();
    endtask

    task automatic test_hold();
        quiet();
        memenM = 1; sizeM = 2; addrM = 32'h4000; data_addr_ok = 1;
        step();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1234_5678; stall_other = 1;
        @(negedge clk);
        checks++; if (rdataM !== 32'h1234_5678 || stall_memM !== 1'b0) begin
            failures++; $display("FAIL hold_dok got rdata=%0h stall=%0h exp 12345678/0", rdataM, stall_memM);
        end
        step();
        for (int c = 0; c < 4; c++) begin
            data_data_ok = 0; data_rdata = $urandom; stall_other = (c < 3);
            @(negedge clk);
            checks++; if (data_req !== 1'b0 || stall_memM !== 1'b0 || rdataM !== 32'h1234_5678) begin
                failures++; $display("FAIL hold_c%0d got req=%0h stall=%0h rdata=%0h exp 0/0/12345678", c, data_req, stall_memM, rdataM);
            end
            step();
        end
        quiet();
        step();
    endtask

    task automatic test_exc();
        quiet();
        memenM = 1; excM = 1; addrM = 32'h5000;
        for (int c = 0; c < 3; c++) begin
            data_addr_ok = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++; if (data_req !== 1'b0 || stall_memM !== 1'b0) begin
                failures++; $display("FAIL exc_c%0d got req=%0h stall=%0h exp 0/0", c, data_req, stall_memM);
            end
            step();
        end
        quiet();
        step();
    endtask

    task automatic test_store_half();
        quiet();
        memenM = 1; memwriteM = 1; sizeM = 1; addrM = 32'h3002; wdataM = 32'h7777_ABCD; data_addr_ok = 1;
        @(negedge clk);
        checks++; if (data_wdata !== 32'hABCD_ABCD || data_size !== 2'd1 || data_wr !== 1'b1 || data_addr !== 32'h3002) begin
            failures++; $display("FAIL sh got wdata=%0h size=%0h wr=%0h addr=%0h exp abcdabcd/1/1/3002", data_wdata, data_size, data_wr, data_addr);
        end
        step();
        data_addr_ok = 0; data_data_ok = 1;
        step();
        quiet();
        step();
    endtask

    task automatic test_reset_in_addr();
        quiet();
        memenM = 1; sizeM = 2; addrM = 32'h6000;
        step();
        resetn = 0;
        step();
        quiet();
        resetn = 1;
        @(negedge clk);
        checks++; if (data_req !== 1'b0 || stall_memM !== 1'b0 || rdataM !== 32'h0) begin
            failures++; $display("FAIL rst_addr got req=%0h stall=%0h rdata=%0h exp 0/0/0", data_req, stall_memM, rdataM);
        end
        step();
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, exp_wd, last_rd;
        logic [1:0]  sz, exp_sz;
        logic        wr;
        int          da, dd, h;
        last_rd = 32'h0;
        for (int n = 0; n < 40; n++) begin
            a = $urandom; wd = $urandom; rd = $urandom;
            sz = 2'($urandom_range(0, 3)); wr = 1'($urandom_range(0, 1));
            da = $urandom_range(0, 3); dd = $urandom_range(1, 3); h = $urandom_range(0, 3);
            exp_sz = (sz == 2'd3) ? 2'd2 : sz;
            exp_wd = repl(exp_sz, wd);
            for (int t = 0; t <= da + dd; t++) begin
                memenM = 1; memwriteM = wr; sizeM = sz; addrM = a; wdataM = wd;
                excM = (t > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                data_addr_ok = (t == da) ? 1'b1 : ((t > da) ? 1'($urandom_range(0, 1)) : 1'b0);
                data_data_ok = (t == da + dd) ? 1'b1 : ((t <= da) ? 1'($urandom_range(0, 1)) : 1'b0);
                data_rdata   = (t == da + dd) ? rd : $urandom;
                stall_other  = (t == da + dd) ? (h > 0) : 1'($urandom_range(0, 1));
                @(negedge clk);
                checks++; if (data_req !== (t <= da)) begin
                    failures++; $display("FAIL rnd_req n=%0d t=%0d got=%0h exp=%0h", n, t, data_req, (t <= da));
                end
                if (t <= da) begin
                    checks++; if (data_addr !== a || data_size !== exp_sz || data_wr !== wr || data_wdata !== exp_wd) begin
                        failures++; $display("FAIL rnd_bus n=%0d t=%0d got %0h/%0h/%0h/%0h exp %0h/%0h/%0h/%0h", n, t,
                                             data_addr, data_size, data_wr, data_wdata, a, exp_sz, wr, exp_wd);
                    end
                end
                checks++; if (stall_memM !== (t < da + dd)) begin
                    failures++; $display("FAIL rnd_stall n=%0d t=%0d got=%0h exp=%0h", n, t, stall_memM, (t < da + dd));
                end
                if (t == da + dd) begin
                    checks++; if (rdataM !== rd) begin
                        failures++; $display("FAIL rnd_rdata n=%0d got=%0h exp=%0h", n, rdataM, rd);
                    end
                end
                step();
            end
            last_rd = rd;
            for (int k = 1; k <= h; k++) begin
                excM = 0; stall_other = (k < h);
                data_addr_ok = 1'($urandom_range(0, 1)); data_data_ok = 1'($urandom_range(0, 1)); data_rdata = $urandom;
                @(negedge clk);
                checks++; if (data_req !== 1'b0 || stall_memM !== 1'b0 || rdataM !== last_rd) begin
                    failures++; $display("FAIL rnd_hold n=%0d k=%0d got req=%0h stall=%0h rdata=%0h exp 0/0/%0h",
                                         n, k, data_req, stall_memM, rdataM, last_rd);
                end
                step();
            end
            if ($urandom_range(0, 1) == 1) begin
                quiet(); data_addr_ok = 1'($urandom_range(0, 1)); data_data_ok = 1'($urandom_range(0, 1)); data_rdata = $urandom;
                @(negedge clk);
                checks++; if (data_req !== 1'b0 || stall_memM !== 1'b0 || rdataM !== last_rd) begin
                    failures++; $display("FAIL rnd_idle n=%0d got req=%0h stall=%0h rdata=%0h exp 0/0/%0h",
                                         n, data_req, stall_memM, rdataM, last_rd);
                end
                step();
            end
        end
        quiet();
        step();
    endtask

    initial begin
        quiet();
        resetn = 0;
        test_reset();
        test_load_word();
        test_store_byte_delayed();
        test_hold();
        test_exc();
        test_store_half();
        test_reset_in_addr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
